ik_result_port: RTL and testbench

//  CPU-facing read side of the IK peripheral: the IK solver pushes completed joint-angle

---
 rtl/ik_pkg.sv | 28 ++
 rtl/ik_result_fifo.sv | 74 +++++++
 rtl/ik_result_port.sv | 110 +++++++++++
 tb/tb_ik_result_port.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ik_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ik_pkg : shared IK peripheral types, register addresses, bit positions   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package ik_pkg;

  localparam int IK_DATA_W = 32;
  typedef logic [IK_DATA_W-1:0] angle_t;

  localparam int          IK_ADDR_W       = 5;
  localparam logic [4:0]  IK_ADDR_STATUS  = 5'h00;
  localparam logic [4:0]  IK_ADDR_ANGLE0  = 5'h01;
  localparam logic [4:0]  IK_ADDR_CONTROL = 5'h08;

  localparam int IK_CTRL_POP       = 0;
  localparam int IK_CTRL_CLR_STALL = 1;
  localparam int IK_CTRL_IRQ_EN    = 2;
  localparam int IK_CTRL_FLUSH     = 3;

  localparam int IK_STAT_EMPTY     = 0;
  localparam int IK_STAT_FULL      = 1;
  localparam int IK_STAT_STALL     = 2;
  localparam int IK_STAT_IRQ_EN    = 3;
  localparam int IK_STAT_COUNT_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/ik_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ik_result_fifo : synchronous FIFO with flush, count and head-data output |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ik_result_fifo #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  import ik_pkg::*;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Push is refused while full even if a pop lands the same edge; flush beats both.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/ik_result_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ik_result_port : Avalon-MM read side for buffered IK joint-angle results |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ik_result_port
  import ik_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_JOINTS = 3,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [NUM_JOINTS*DATA_W-1:0] res_angle,
  input  logic                         chipselect,
  input  logic                         read,
  input  logic                         write,
  input  logic [4:0]                   address,
  input  logic [DATA_W-1:0]            writedata,
  output logic [DATA_W-1:0]            readdata,
  output logic                         irq
);

  localparam int SET_W = NUM_JOINTS * DATA_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              ctrl_wr;
  logic              rd_en;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SET_W-1:0]  head;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] status;
  logic              stall_q, stall_d;
  logic              irq_en_q, irq_en_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              wdata_unused;

  assign ctrl_wr      = chipselect && write && (address == IK_ADDR_CONTROL);
  assign rd_en        = chipselect && read;
  assign fifo_pop     = ctrl_wr && writedata[IK_CTRL_POP];
  assign fifo_flush   = ctrl_wr && writedata[IK_CTRL_FLUSH];
  assign res_ready    = !fifo_full;
  assign wdata_unused = ^writedata[DATA_W-1:4];

  ik_result_fifo #(
    .WIDTH (SET_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (res_valid),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (res_angle),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status                                 = '0;
    status[IK_STAT_EMPTY]                  = fifo_empty;
    status[IK_STAT_FULL]                   = fifo_full;
    status[IK_STAT_STALL]                  = stall_q;
    status[IK_STAT_IRQ_EN]                 = irq_en_q;
    status[IK_STAT_COUNT_LSB +: CNT_W]     = count;

    // A refused offer in the same edge as a clear keeps the stall visible.
    stall_d = stall_q;
    if (ctrl_wr && writedata[IK_CTRL_CLR_STALL]) stall_d = 1'b0;
    if (res_valid && fifo_full)                  stall_d = 1'b1;

    irq_en_d = irq_en_q;
    if (ctrl_wr) irq_en_d = writedata[IK_CTRL_IRQ_EN];

    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      if (address == IK_ADDR_STATUS) readdata_d = status;
      for (int j = 0; j < NUM_JOINTS; j++) begin
        if ((address == IK_ADDR_ANGLE0 + 5'(j)) && !fifo_empty)
          readdata_d = head[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      stall_q    <= stall_d;
      irq_en_q   <= irq_en_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_en_q && !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_ik_result_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ik_result_port : self-checking bench with a queue-based result model  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_ik_result_port;

  localparam int DW = 32;
  localparam int NJ = 3;
  localparam int DP = 4;

  logic           clk;
  logic           reset;
  logic           res_valid;
  logic           res_ready;
  logic [NJ*DW-1:0] res_angle;
  logic           chipselect;
  logic           read;
  logic           write;
  logic [4:0]     address;
  logic [DW-1:0]  writedata;
  logic [DW-1:0]  readdata;
  logic           irq;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of whole result sets plus the two sticky bits.
  logic [NJ*DW-1:0] mq[$];
  bit               m_stall;
  bit               m_irq_en;

  ik_result_port #(.DATA_W(DW), .NUM_JOINTS(NJ), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_angle  (res_angle),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(mq.size()), 4'h0, m_irq_en, m_stall,
            (mq.size() == DP), (mq.size() == 0)};
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [NJ*DW-1:0] h;
    if (a == 5'h00) return exp_status();
    if (a >= 5'h01 && a <= 5'(NJ) && mq.size() > 0) begin
      h = mq[0];
      return h[(int'(a) - 1)*DW +: DW];
    end
    return 32'h0;
  endfunction

  function automatic logic [NJ*DW-1:0] rand_set();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic do_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk); chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk); chipselect = 1'b0; read = 1'b0;
    @(negedge clk); d = readdata;
  endtask

  // Drives one CONTROL write and applies the same edge to the model; res_valid
  // is assumed steady across the write.
  task automatic do_ctrl(input logic [3:0] v);
    bit pre_full;
    @(negedge clk); chipselect = 1'b1; write = 1'b1; address = 5'h08; writedata = {28'h0, v};
    @(negedge clk); chipselect = 1'b0; write = 1'b0;
    pre_full = (mq.size() == DP);
    if (v[3]) mq.delete();
    else begin
      if (v[0] && mq.size() > 0) void'(mq.pop_front());
      if (res_valid && !pre_full) mq.push_back(res_angle);
    end
    if (v[1]) m_stall = 1'b0;
    if (res_valid && pre_full) m_stall = 1'b1;
    m_irq_en = v[2];
  endtask

  task automatic do_push(input logic [NJ*DW-1:0] s);
    @(negedge clk); res_valid = 1'b1; res_angle = s;
    @(negedge clk); res_valid = 1'b0;
    if (mq.size() < DP) mq.push_back(s);
    else m_stall = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_push({32'd3, 32'd2, 32'd1});
    do_ctrl(4'h4);
    do_read(5'h01, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL reset_pre_read: got %h expected %h", d, 32'd1); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reset_pre_irq: got %b expected 1", irq); end
    @(negedge clk); chipselect = 1'b1; read = 1'b1; address = 5'h01;
    #2 reset = 1'b1;
    #1;
    mq.delete(); m_stall = 1'b0; m_irq_en = 1'b0;
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", res_ready); end
    @(negedge clk);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_pending_read: got %h expected 0", readdata); end
    chipselect = 1'b0; read = 1'b0;
    @(negedge clk); reset = 1'b0;
    do_read(5'h00, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h1); end
  endtask

  task automatic test_basic_read();
    logic [31:0] d;
    logic [31:0] want [3];
    want[0] = 32'd10; want[1] = 32'd20; want[2] = 32'd30;
    do_push({32'd30, 32'd20, 32'd10});
    for (int j = 0; j < NJ; j++) begin
      do_read(5'(j + 1), d);
      checks++; if (d !== want[j]) begin errors++; $display("FAIL basic_angle%0d: got %h expected %h", j, d, want[j]); end
    end
    do_read(5'h00, d);
    checks++; if (d !== 32'h0100) begin errors++; $display("FAIL basic_status: got %h expected %h", d, 32'h0100); end
    do_read(5'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_unmapped4: got %h expected 0", d); end
    do_read(5'h1F, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_unmapped1f: got %h expected 0", d); end
    do_ctrl(4'h1);
    do_read(5'h00, d);
    checks++; if (d !== 32'h0001) begin errors++; $display("FAIL basic_after_pop: got %h expected %h", d, 32'h0001); end
  endtask

  task automatic test_full_stall();
    logic [31:0] d;
    for (int i = 0; i < DP; i++) do_push(rand_set());
    @(negedge clk); res_valid = 1'b1; res_angle = rand_set();
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", res_ready); end
    @(negedge clk); m_stall = 1'b1;
    do_read(5'h00, d);
    checks++; if (d !== 32'h0406) begin errors++; $display("FAIL full_status: got %h expected %h", d, 32'h0406); end
    do_ctrl(4'h2);
    do_read(5'h00, d);
    checks++; if (d !== 32'h0406) begin errors++; $display("FAIL stall_clear_while_offer: got %h expected %h", d, 32'h0406); end
    res_valid = 1'b0;
    do_ctrl(4'h2);
    do_read(5'h00, d);
    checks++; if (d !== 32'h0402) begin errors++; $display("FAIL stall_cleared: got %h expected %h", d, 32'h0402); end
  endtask

  task automatic test_pop_push_full();
    logic [31:0] d;
    logic [NJ*DW-1:0] x;
    x = rand_set();
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 5'h08; writedata = 32'h1;
    res_valid = 1'b1; res_angle = x;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    void'(mq.pop_front()); m_stall = 1'b1;
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL popfull_ready: got %b expected 1", res_ready); end
    @(negedge clk);
    res_valid = 1'b0;
    mq.push_back(x);
    do_read(5'h00, d);
    checks++; if (d !== 32'h0406) begin errors++; $display("FAIL popfull_status: got %h expected %h", d, 32'h0406); end
    for (int k = 0; k < DP; k++) begin
      for (int j = 0; j < NJ; j++) begin
        do_read(5'(j + 1), d);
        checks++; if (d !== exp_read(5'(j + 1))) begin errors++; $display("FAIL popfull_drain e%0d j%0d: got %h expected %h", k, j, d, exp_read(5'(j + 1))); end
      end
      do_ctrl(4'h1);
    end
    do_ctrl(4'h2);
  endtask

  task automatic test_empty_wrap();
    logic [31:0] d;
    logic [NJ*DW-1:0] s;
    do_ctrl(4'h1);
    do_read(5'h00, d);
    checks++; if (d !== 32'h0001) begin errors++; $display("FAIL empty_pop_status: got %h expected %h", d, 32'h0001); end
    for (int j = 0; j < NJ; j++) begin
      do_read(5'(j + 1), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL empty_angle%0d: got %h expected 0", j, d); end
    end
    for (int i = 0; i < 9; i++) begin
      s = rand_set();
      do_push(s);
      for (int j = 0; j < NJ; j++) begin
        do_read(5'(j + 1), d);
        checks++; if (d !== s[j*DW +: DW]) begin errors++; $display("FAIL wrap i%0d j%0d: got %h expected %h", i, j, d, s[j*DW +: DW]); end
      end
      do_ctrl(4'h1);
    end
    do_read(5'h00, d);
    checks++; if (d !== 32'h0001) begin errors++; $display("FAIL wrap_status: got %h expected %h", d, 32'h0001); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    do_push(rand_set());
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b expected 0", irq); end
    do_ctrl(4'h4);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_enabled: got %b expected 1", irq); end
    do_ctrl(4'hC);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_flush: got %b expected 0", irq); end
    do_read(5'h00, d);
    checks++; if (d !== 32'h0009) begin errors++; $display("FAIL flush_status: got %h expected %h", d, 32'h0009); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [NJ*DW-1:0] s;
    logic [3:0] v;
    logic [4:0] a;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          s = rand_set();
          @(negedge clk); res_valid = 1'b1; res_angle = s;
          checks++; if (res_ready !== (mq.size() < DP)) begin errors++; $display("FAIL rnd_ready step%0d: got %b expected %b", i, res_ready, (mq.size() < DP)); end
          @(negedge clk); res_valid = 1'b0;
          if (mq.size() < DP) mq.push_back(s); else m_stall = 1'b1;
        end
        1: begin
          v = 4'($urandom_range(0, 7));
          if ($urandom_range(0, 9) == 0) v[3] = 1'b1;
          do_ctrl(v);
        end
        default: begin
          a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
          do_read(a, d);
          checks++; if (d !== exp_read(a)) begin errors++; $display("FAIL rnd_read step%0d addr %h: got %h expected %h", i, a, d, exp_read(a)); end
        end
      endcase
      checks++; if (irq !== (m_irq_en && mq.size() > 0)) begin errors++; $display("FAIL rnd_irq step%0d: got %b expected %b", i, irq, (m_irq_en && mq.size() > 0)); end
    end
  endtask

  initial begin
    reset = 1'b1; res_valid = 1'b0; res_angle = '0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    m_stall = 1'b0; m_irq_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic_read();
    test_full_stall();
    test_pop_push_full();
    test_empty_wrap();
    test_irq();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
